// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: round-robin arbiter/sequencer sharing one single-port memory between
// NUM_REQ requesters. One transaction at a time. A write takes 2 cycles and a read takes
// RD_LAT+2 cycles. Read data is returned to the winning requester.
//
// Ports:
//   clock, reset       - system clock; synchronous active-high reset
//   req/req_we         - per-requester request and write flag (held until gnt)
//   req_addr/req_wdata - packed per-requester address / write data
//   gnt                - one-hot acceptance pulse, asserted in the ISSUE cycle
//   rd_valid/rd_data   - one-hot read-return pulse and the read data, which is held
//   busy               - arbiter not idle
//   mem_*              - single-port memory command/data pins
//
// Build option: define MEM_ARB_FIXED_PRIO_EN for fixed priority, where requester 0 is
// highest. In that build the round-robin pointer is tied to 0.
module mem_access_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy,
  output logic                      mem_chip_en,
  output logic                      mem_read_write,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data_in,
  input  logic [DATA_W-1:0]         mem_data_out
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [2:0] LatInit = 3'(RD_LAT - 1);
  localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [NUM_REQ-1:0]  rd_valid_q, rd_valid_d;

  logic [IdxW-1:0]     rr_ptr;
  logic [IdxW-1:0]     win_idx;
  logic                win_found;
  int unsigned         scan;

  // Winner is the first set request scanning upward from rr_ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan = (32'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && req[IdxW'(scan)]) begin
        win_found = 1'b1;
        win_idx   = IdxW'(scan);
      end
    end
  end

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

  assign rr_ptr = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == StIdle && win_found) begin
      rr_ptr_d = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Next-state logic and outputs.
  always_comb begin
    state_d        = state_q;
    win_d          = win_q;
    we_d           = we_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    cnt_d          = cnt_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = '0;
    gnt            = '0;
    mem_chip_en    = 1'b0;
    mem_read_write = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          win_d   = win_idx;
          we_d    = req_we[win_idx];
          addr_d  = req_addr[32'(win_idx) * ADDR_W +: ADDR_W];
          wdata_d = req_wdata[32'(win_idx) * DATA_W +: DATA_W];
          state_d = StIssue;
        end
      end
      StIssue: begin
        gnt            = OneHot0 << win_q;
        mem_chip_en    = 1'b1;
        mem_read_write = we_q;
        if (we_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = LatInit;
          state_d = StWaitRd;
        end
      end
      StWaitRd: begin
        if (cnt_q == 3'd0) begin
          // Memory output is valid in this cycle; the return pulse follows next cycle.
          rd_data_d  = mem_data_out;
          rd_valid_d = OneHot0 << win_q;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      win_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Address and write data are only reloaded on a grant decision, so they hold outside ISSUE.
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_mem_access_arbiter.sv
module tb_mem_access_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned RD_LAT  = 1;

  logic                      clock = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [DATA_W-1:0]         rd_data;
  logic                      busy;
  logic                      mem_chip_en;
  logic                      mem_read_write;
  logic [ADDR_W-1:0]         mem_address;
  logic [DATA_W-1:0]         mem_data_in;
  logic [DATA_W-1:0]         mem_data_out;

  always #5 clock = ~clock;

  mem_access_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .gnt           (gnt),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .busy          (busy),
    .mem_chip_en   (mem_chip_en),
    .mem_read_write(mem_read_write),
    .mem_address   (mem_address),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out)
  );

  // Single-port memory with a one-cycle read latency.
  logic [DATA_W-1:0] mem [256];
  always @(posedge clock) begin
    if (mem_chip_en) begin
      if (mem_read_write) mem[mem_address] <= mem_data_in;
      else                mem_data_out <= mem[mem_address];
    end
  end

  typedef struct packed {
    logic [NUM_REQ-1:0] gnt;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
  } gnt_exp_t;

  typedef struct packed {
    logic [NUM_REQ-1:0] vld;
    logic [DATA_W-1:0]  data;
  } rd_exp_t;

  gnt_exp_t          gnt_sb[$];
  rd_exp_t           rd_sb[$];
  logic [DATA_W-1:0] exp_mem [256];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata);
    req[idx]                        = 1'b1;
    req_we[idx]                     = we;
    req_addr[idx*ADDR_W +: ADDR_W]  = addr;
    req_wdata[idx*DATA_W +: DATA_W] = wdata;
  endtask

  task automatic expect_gnt(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata);
    gnt_exp_t e;
    e.gnt   = NUM_REQ'(1) << idx;
    e.we    = we;
    e.addr  = addr;
    e.wdata = wdata;
    gnt_sb.push_back(e);
    if (we) exp_mem[addr] = wdata;
  endtask

  task automatic expect_rd(input int idx, input logic [ADDR_W-1:0] addr);
    rd_exp_t e;
    e.vld  = NUM_REQ'(1) << idx;
    e.data = exp_mem[addr];
    rd_sb.push_back(e);
  endtask

  task automatic wait_gnt(input string tag, output int cyc);
    gnt_exp_t e;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (gnt == '0 && cyc < 20);
    check({tag, "_seen"}, 64'(|gnt), 64'd1);
    e = gnt_sb.pop_front();
    check({tag, "_gnt"}, 64'(gnt), 64'(e.gnt));
    check({tag, "_chip_en"}, 64'(mem_chip_en), 64'd1);
    check({tag, "_rw"}, 64'(mem_read_write), 64'(e.we));
    check({tag, "_addr"}, 64'(mem_address), 64'(e.addr));
    if (e.we) check({tag, "_wdata"}, 64'(mem_data_in), 64'(e.wdata));
  endtask

  task automatic wait_rd(input string tag, output int cyc);
    rd_exp_t e;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (rd_valid == '0 && cyc < 20);
    e = rd_sb.pop_front();
    check({tag, "_rd_valid"}, 64'(rd_valid), 64'(e.vld));
    check({tag, "_rd_data"}, 64'(rd_data), 64'(e.data));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rd_seen;
    int g0;
    int gother;
    for (int i = 0; i < 256; i++) exp_mem[i] = '0;
    reset     = 1'b1;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_chip_en", 64'(mem_chip_en), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);

    // Single write from requester 0
    drive(0, 1'b1, 8'h10, 8'hA5);
    expect_gnt(0, 1'b1, 8'h10, 8'hA5);
    wait_gnt("t1", cyc);
    check("t1_gnt_lat", 64'(cyc), 64'd1);
    req = '0;
    tick();
    check("t1_busy_low", 64'(busy), 64'd0);

    // Read back from requester 0
    drive(0, 1'b0, 8'h10, 8'h00);
    expect_gnt(0, 1'b0, 8'h10, 8'h00);
    expect_rd(0, 8'h10);
    wait_gnt("t2", cyc);
    check("t2_gnt_lat", 64'(cyc), 64'd1);
    req = '0;
    wait_rd("t2", cyc);
    check("t2_rd_lat", 64'(cyc), 64'(RD_LAT + 1));
    tick();
    check("t2_rd_valid_pulse", 64'(rd_valid), 64'd0);
    check("t2_rd_data_hold", 64'(rd_data), 64'hA5);

`ifndef MEM_ARB_FIXED_PRIO_EN
    // All requesters held: round-robin order from pointer 0 with wrap
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 1'b1, 8'(8'h40 + i), 8'(8'h30 + i));
    for (int k = 0; k < 5; k++) expect_gnt(k % 4, 1'b1, 8'(8'h40 + k % 4), 8'(8'h30 + k % 4));
    for (int k = 0; k < 5; k++) begin
      wait_gnt($sformatf("t3_%0d", k), cyc);
      check($sformatf("t3_%0d_spacing", k), 64'(cyc), (k == 0) ? 64'd1 : 64'd2);
    end
    req = '0;
    tick();

    // Grant to 2 moves the pointer to 3; 0101 must then grant 0 before 2
    drive(2, 1'b1, 8'h52, 8'h77);
    expect_gnt(2, 1'b1, 8'h52, 8'h77);
    wait_gnt("t4a", cyc);
    req = '0;
    tick();
    drive(0, 1'b1, 8'h60, 8'h11);
    drive(2, 1'b1, 8'h62, 8'h22);
    expect_gnt(0, 1'b1, 8'h60, 8'h11);
    expect_gnt(2, 1'b1, 8'h62, 8'h22);
    wait_gnt("t4b", cyc);
    wait_gnt("t4c", cyc);
    req = '0;
    tick();
`endif

    // Read from requester 2, reset during WAIT_RD drops the return
    drive(2, 1'b0, 8'h52, 8'h00);
    expect_gnt(2, 1'b0, 8'h52, 8'h00);
    wait_gnt("t5", cyc);
    req = '0;
    tick();
    check("t5_busy_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_gnt", 64'(gnt), 64'd0);
    check("t5_rd_valid", 64'(rd_valid), 64'd0);
    check("t5_rd_data", 64'(rd_data), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_chip_en", 64'(mem_chip_en), 64'd0);
    check("t5_rw", 64'(mem_read_write), 64'd0);
    check("t5_addr", 64'(mem_address), 64'd0);
    check("t5_wdata", 64'(mem_data_in), 64'd0);
    rd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_valid != '0) rd_seen++;
    end
    check("t5_no_rd_valid", 64'(rd_seen), 64'd0);
    drive(2, 1'b1, 8'h70, 8'h01);
    drive(3, 1'b1, 8'h73, 8'h03);
    expect_gnt(2, 1'b1, 8'h70, 8'h01);
    wait_gnt("t5_after", cyc);
    check("t5_after_lat", 64'(cyc), 64'd1);
    req = '0;
    tick();

`ifdef MEM_ARB_FIXED_PRIO_EN
    // Fixed priority: requester 3 starves behind requester 0
    do_reset();
    drive(0, 1'b1, 8'h80, 8'h0F);
    drive(3, 1'b1, 8'h83, 8'hF0);
    g0     = 0;
    gother = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (gnt == 4'b0001) g0++;
      else if (gnt != '0) gother++;
    end
    check("fp_g0_count", 64'(g0), 64'd10);
    check("fp_other_count", 64'(gother), 64'd0);
    req = '0;
    tick();
`else
    g0     = 0;
    gother = 0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port memory (the mem_ports memory DUT) between NUM_REQ requesters.
- Accepts one read or write per grant, drives the memory command for exactly one cycle, and returns read data to the winning requester after the memory read latency.
- Sits between the testbench/IP request sources and the memory port pins.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 8, memory address width
DATA_W, 8, memory data width
RD_LAT, 1, cycles from the chip_en cycle to mem_data_out valid (1..4)

Ports:
clock  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high
req  input  NUM_REQ  per-requester request, held until gnt
req_we  input  NUM_REQ  per-requester 1=write, 0=read
req_addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  NUM_REQ*DATA_W  packed write data
gnt  output  NUM_REQ  one-hot, one-cycle acceptance pulse
rd_valid  output  NUM_REQ  one-hot, one-cycle read-return pulse
rd_data  output  DATA_W  read data, valid when any rd_valid
busy  output  1  state != IDLE
mem_chip_en  output  1  memory command strobe
mem_read_write  output  1  1=write, 0=read
mem_address  output  ADDR_W  memory address
mem_data_in  output  DATA_W  memory write data
mem_data_out  input  DATA_W  memory read data

Behaviour:
- Interface: one clock (clock). Reset (reset) is synchronous and active-high.
- Reset:
  - All outputs 0; state IDLE; rr_ptr=0.
  - A transaction in flight is dropped; no rd_valid follows.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If req is nonzero in cycle t, select the winner: the first set bit scanning from rr_ptr upward with wrap.
  - Register the winner's we/addr/wdata and go to ISSUE.
  - rr_ptr becomes (winner+1) mod NUM_REQ.
- ISSUE (cycle t+1):
  - gnt[winner]=1, mem_chip_en=1, mem_read_write=we, mem_address/mem_data_in driven from the registered values.
  - Write: go to IDLE.
  - Read: go to WAIT_RD with wait counter = RD_LAT-1.
- WAIT_RD:
  - Decrement the counter.
  - At 0, capture mem_data_out into rd_data; rd_valid[winner]=1 in the following cycle (t+2+RD_LAT); return to IDLE.
- Outputs when not in ISSUE:
  - mem_chip_en, mem_read_write and gnt are 0.
  - mem_address and mem_data_in hold their last value.
- rd_data holds until the next read return.
- Handshake:
  - Requester keeps req/req_we/req_addr/req_wdata stable until it sees gnt, then may drop req or present a new command.
  - req is sampled only in IDLE. A requester that keeps req high after gnt re-enters arbitration behind the others.
- Throughput:
  - Write: one per 2 cycles.
  - Read: one per RD_LAT+2 cycles.
  - No overlap of transactions.
- Fairness: with all requesters asserted, grant order is 0,1,...,NUM_REQ-1,0,...; any requester is served within NUM_REQ grants.
- Boundaries:
  - req changing while busy is ignored until IDLE.
  - A single requester is served back-to-back every transaction slot.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - Reset asserted in the same cycle as a grant decision gives priority to reset.

Optional Feature:
MEM_ARB_FIXED_PRIO_EN
- Defined: requester 0 has highest priority, then 1, and so on. rr_ptr is removed (tied 0, no update). Lower-priority requesters may starve.
- Undefined: round-robin as specified above.

Test Plan:
- Reset then req=0001, we=1, addr=0x10, wdata=0xA5 -> gnt=0001 at cycle 1; mem_chip_en=1, mem_read_write=1, mem_address=0x10, mem_data_in=0xA5 in the same cycle; busy low at cycle 2.
- After that write, req=0001, we=0, addr=0x10, RD_LAT=1 -> gnt at t+1; rd_valid=0001 with rd_data=0xA5 at t+3; no other rd_valid bit set.
- req=1111 held, all writes -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive issue slots, 2 cycles apart.
- rr_ptr=3 (after a grant to 2), req=0101 -> grant 0001 first, then 0100.
- Read issued to requester 2; reset pulsed in the WAIT_RD cycle -> no rd_valid ever; all outputs 0; next grant is to the lowest set req from 0.
- With MEM_ARB_FIXED_PRIO_EN and req=1001 held continuously -> gnt always 0001; requester 3 is never granted during a 20-cycle window.
